// File: rtl/bc_msg_pkg.sv
// Broadcast message format shared by the cores, the arbiter and the fan-out.
// Layout, MSB to LSB: {data[31:0], strb[3:0], addr[10:0]}.
package bc_msg_pkg;

   localparam int BC_DATA_W = 32;
   localparam int BC_STRB_W = 4;
   localparam int BC_ADDR_W = 11;   // word address into an 8192-byte region
   localparam int BC_MSG_W  = BC_DATA_W + BC_STRB_W + BC_ADDR_W;

   // Field offsets inside a packed message.
   localparam int BC_ADDR_LSB = 0;
   localparam int BC_STRB_LSB = BC_ADDR_W;
   localparam int BC_DATA_LSB = BC_ADDR_W + BC_STRB_W;
   localparam int BC_DATA_MSB = BC_MSG_W - 1;

   typedef struct packed {
      logic [BC_DATA_W-1:0] data;
      logic [BC_STRB_W-1:0] strb;
      logic [BC_ADDR_W-1:0] addr;
   } bc_msg_t;

   // Builds a flat message from its fields.
   function automatic logic [BC_MSG_W-1:0] bc_pack(input logic [BC_DATA_W-1:0] d,
                                                   input logic [BC_STRB_W-1:0] s,
                                                   input logic [BC_ADDR_W-1:0] a);
      return {d, s, a};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr,
// wrapping from N-1 back to 0. Produces a one-hot grant and its index.
module rr_arbiter
   import bc_msg_pkg::*;
#(
   parameter int N   = 16,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_ptr,
   output logic [N-1:0]   o_grant,
   output logic [IDW-1:0] o_idx,
   output logic           o_any
);

   // Scan N positions starting at the pointer; the first hit wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         int pos;
         pos = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[pos]) begin
            o_any        = 1'b1;
            o_grant[pos] = 1'b1;
            o_idx        = IDW'(pos);
         end
      end
   end

endmodule

// File: rtl/bc_msg_arbiter.sv
// Serialises per-core broadcast messages onto a single registered broadcast
// bus, round-robin per accepted message, with message/stall statistics.
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. Upstream, s_msg_ready[i] is offered only to the granted core and only
// when the output register can take a message; it does not wait for valid
// beyond the grant. Downstream, m_msg_* holds stable while m_msg_valid is high
// and m_msg_ready is low.
module bc_msg_arbiter
   import bc_msg_pkg::*;
#(
   parameter int CORE_COUNT    = 16,
   parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
   parameter int MSG_WIDTH     = BC_MSG_W,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg_data,
   input  logic [CORE_COUNT-1:0]           s_msg_valid,
   output logic [CORE_COUNT-1:0]           s_msg_ready,
   input  logic [CORE_COUNT-1:0]           core_mask,
   output logic [MSG_WIDTH-1:0]            m_msg_data,
   output logic [CORE_ID_WIDTH-1:0]        m_msg_src,
   output logic                            m_msg_valid,
   input  logic                            m_msg_ready,
   output logic [CNT_WIDTH-1:0]            msg_count,
   output logic [CNT_WIDTH-1:0]            stall_count,
   input  logic                            stat_clear
);

   logic [CORE_ID_WIDTH-1:0] r_ptr;
   logic [MSG_WIDTH-1:0]     r_data;
   logic [CORE_ID_WIDTH-1:0] r_src;
   logic                     r_valid;
   logic [CNT_WIDTH-1:0]     r_msg_cnt;
   logic [CNT_WIDTH-1:0]     r_stall_cnt;

   logic [CORE_COUNT-1:0]    w_req;
   logic [CORE_COUNT-1:0]    w_grant;
   logic [CORE_ID_WIDTH-1:0] w_idx;
   logic                     w_any;
   logic                     w_load;
   logic                     w_stall;
   logic [MSG_WIDTH-1:0]     w_sel_data;
   logic [CORE_ID_WIDTH-1:0] w_ptr_nxt;

   // Masked cores never compete, whatever their valid says.
   assign w_req = s_msg_valid & core_mask;

   rr_arbiter #(
      .N   (CORE_COUNT),
      .IDW (CORE_ID_WIDTH)
   ) u_rr_arbiter (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Accept when someone asks and the output register is empty or draining.
   // Held reset blocks acceptance so no core believes it was taken.
   assign w_load      = rst_n && w_any && (!r_valid || m_msg_ready);
   assign w_stall     = r_valid && !m_msg_ready;
   assign s_msg_ready = w_load ? w_grant : '0;
   assign w_sel_data  = s_msg_data[w_idx*MSG_WIDTH +: MSG_WIDTH];
   assign w_ptr_nxt   = (w_idx == CORE_ID_WIDTH'(CORE_COUNT - 1)) ? '0 : w_idx + 1'b1;

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_data  <= '0;
         r_src   <= '0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_data  <= w_sel_data;
         r_src   <= w_idx;
         r_valid <= 1'b1;
         r_ptr   <= w_ptr_nxt;
      end else if (r_valid && m_msg_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Statistics counters; clear beats a coincident increment, wrap is silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_msg_cnt   <= '0;
         r_stall_cnt <= '0;
      end else if (stat_clear) begin
         r_msg_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_load)  r_msg_cnt   <= r_msg_cnt + 1'b1;
         if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign m_msg_data  = r_data;
   assign m_msg_src   = r_src;
   assign m_msg_valid = r_valid;
   assign msg_count   = r_msg_cnt;
   assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Bench for bc_msg_arbiter: spec-level model checked every cycle, plus
// directed scenarios with literal expectations. A second instance with 4-bit
// counters shares the stimulus so counter wrap is reachable in a short run.
module tb_bc_msg_arbiter;
   import bc_msg_pkg::*;

   localparam int NC = 16;
   localparam int MW = BC_MSG_W;
   localparam int IW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NC*MW-1:0] s_msg_data = '0;
   logic [NC-1:0]    s_msg_valid = '0;
   logic [NC-1:0]    core_mask = '0;
   logic             m_msg_ready = 1'b1;
   logic             stat_clear = 1'b0;

   logic [NC-1:0]    s_msg_ready;
   logic [MW-1:0]    m_msg_data;
   logic [IW-1:0]    m_msg_src;
   logic             m_msg_valid;
   logic [31:0]      msg_count;
   logic [31:0]      stall_count;

   logic [NC-1:0]    s_rdy_s;
   logic [MW-1:0]    m_data_s;
   logic [IW-1:0]    m_src_s;
   logic             m_valid_s;
   logic [3:0]       msg_count_s;
   logic [3:0]       stall_count_s;

   bc_msg_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .s_msg_data(s_msg_data), .s_msg_valid(s_msg_valid), .s_msg_ready(s_msg_ready),
      .core_mask(core_mask),
      .m_msg_data(m_msg_data), .m_msg_src(m_msg_src), .m_msg_valid(m_msg_valid),
      .m_msg_ready(m_msg_ready),
      .msg_count(msg_count), .stall_count(stall_count), .stat_clear(stat_clear)
   );

   bc_msg_arbiter #(.CNT_WIDTH(4)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .s_msg_data(s_msg_data), .s_msg_valid(s_msg_valid), .s_msg_ready(s_rdy_s),
      .core_mask(core_mask),
      .m_msg_data(m_data_s), .m_msg_src(m_src_s), .m_msg_valid(m_valid_s),
      .m_msg_ready(m_msg_ready),
      .msg_count(msg_count_s), .stall_count(stall_count_s), .stat_clear(stat_clear)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          mdl_ptr = 0;
   logic        mdl_valid = 1'b0;
   logic [MW-1:0] mdl_data = '0;
   int          mdl_src = 0;
   logic [31:0] mdl_msgs = '0;
   logic [31:0] mdl_stalls = '0;

   // First requesting core at or after ptr, cyclically; -1 when nobody asks.
   function automatic int rr_pick(input logic [NC-1:0] req, input int ptr);
      for (int off = 0; off < NC; off++) begin
         int p;
         p = (ptr + off) % NC;
         if (req[p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [NC-1:0] model_ready();
      int g;
      g = rr_pick(s_msg_valid & core_mask, mdl_ptr);
      if (rst_n && g >= 0 && (!mdl_valid || m_msg_ready)) return NC'(1) << g;
      return '0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_ptr = 0; mdl_valid = 1'b0; mdl_data = '0; mdl_src = 0;
         mdl_msgs = '0; mdl_stalls = '0;
      end else begin
         int  g;
         bit  take;
         bit  stall;
         g     = rr_pick(s_msg_valid & core_mask, mdl_ptr);
         take  = (g >= 0) && (!mdl_valid || m_msg_ready);
         stall = mdl_valid && !m_msg_ready;
         if (stat_clear) begin
            mdl_msgs = '0; mdl_stalls = '0;
         end else begin
            if (take)  mdl_msgs++;
            if (stall) mdl_stalls++;
         end
         if (take) begin
            mdl_data  = s_msg_data[g*MW +: MW];
            mdl_src   = g;
            mdl_valid = 1'b1;
            mdl_ptr   = (g + 1) % NC;
         end else if (mdl_valid && m_msg_ready) begin
            mdl_valid = 1'b0;
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("cyc_s_ready", 64'(s_msg_ready), 64'(model_ready()));
      check("cyc_m_valid", 64'(m_msg_valid), 64'(mdl_valid));
      check("cyc_m_src",   64'(m_msg_src),   64'(mdl_src));
      check("cyc_m_data",  64'(m_msg_data),  64'(mdl_data));
      check("cyc_msg_cnt", 64'(msg_count),   64'(mdl_msgs));
      check("cyc_stl_cnt", 64'(stall_count), 64'(mdl_stalls));
      check("cyc_msg_cnt4", 64'(msg_count_s),   64'(mdl_msgs[3:0]));
      check("cyc_stl_cnt4", 64'(stall_count_s), 64'(mdl_stalls[3:0]));
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_data();
      for (int i = 0; i < NC; i++)
         s_msg_data[i*MW +: MW] = bc_pack(32'hC0DE_0000 + 32'(i * 17), 4'(i), 11'(i * 97));
   endtask

   task automatic pulse_reset();
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      bit seen3;
      int stalls_before;
      load_data();

      // Reset: all cores shout while reset is held; nobody may be accepted.
      s_msg_valid = '1;
      core_mask   = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", 64'(s_msg_ready), 64'h0);
      check("rst_m_valid", 64'(m_msg_valid), 64'h0);
      check("rst_m_data",  64'(m_msg_data),  64'h0);
      check("rst_msg_cnt", 64'(msg_count),   64'h0);
      tick();
      s_msg_valid = '0;
      rst_n = 1'b1;

      // Single request from core 5 (47-bit view of 0x1ABCD_1234_5678).
      tick();
      s_msg_data[5*MW +: MW] = 47'h2BCD_1234_5678;
      s_msg_valid = 16'h0020;
      @(negedge clk);
      check("single_ready", 64'(s_msg_ready), 64'h0020);
      tick();
      s_msg_valid = '0;
      @(negedge clk);
      check("single_valid", 64'(m_msg_valid), 64'h1);
      check("single_src",   64'(m_msg_src),   64'h5);
      check("single_data",  64'(m_msg_data),  64'h2BCD_1234_5678);
      check("single_cnt",   64'(msg_count),   64'h1);
      load_data();

      // Round-robin from ptr 0 over cores 0, 3, 15.
      pulse_reset();
      s_msg_valid = 16'h8009;
      begin
         int exp_seq[6] = '{0, 3, 15, 0, 3, 15};
         for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr_valid", 64'(m_msg_valid), 64'h1);
            check("rr_src",   64'(m_msg_src),   64'(exp_seq[k]));
         end
      end
      tick();
      s_msg_valid = '0;
      tick();

      // Backpressure: hold src 2 for four cycles while core 7 waits.
      s_msg_valid = 16'h0004;
      tick();
      s_msg_valid = 16'h0080;
      m_msg_ready = 1'b0;
      stalls_before = int'(stall_count);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp_src",   64'(m_msg_src),   64'h2);
         check("bp_valid", 64'(m_msg_valid), 64'h1);
         check("bp_ready", 64'(s_msg_ready), 64'h0);
         tick();
      end
      m_msg_ready = 1'b1;
      check("bp_stalls", 64'(int'(stall_count) - stalls_before), 64'h4);
      tick();
      s_msg_valid = '0;
      @(negedge clk);
      check("bp_deliver7", 64'(m_msg_src), 64'h7);

      // Mask: core 3 blocked, core 4 keeps winning; then unmask core 3.
      tick();
      core_mask   = 16'hFFF7;
      s_msg_valid = 16'h0018;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("mask_ready3", 64'(s_msg_ready[3]), 64'h0);
         tick();
         check("mask_src4", 64'(m_msg_src), 64'h4);
      end
      core_mask = 16'hFFFF;
      seen3 = 1'b0;
      for (int k = 0; k < 16 && !seen3; k++) begin
         tick();
         if (m_msg_valid && m_msg_src == 4'd3) seen3 = 1'b1;
      end
      check("mask_core3_delivered", 64'(seen3), 64'h1);
      s_msg_valid = '0;
      tick();

      // Clear wins over a coincident accept, then walk the 4-bit counter round.
      s_msg_valid = 16'h0002;
      stat_clear  = 1'b1;
      tick();
      stat_clear = 1'b0;
      @(negedge clk);
      check("clr_msg_cnt", 64'(msg_count),   64'h0);
      check("clr_stl_cnt", 64'(stall_count), 64'h0);
      for (int k = 1; k <= 15; k++) tick();
      @(negedge clk);
      check("wrap_pre4",  64'(msg_count_s), 64'hF);
      check("wrap_pre32", 64'(msg_count),   64'd15);
      tick();
      s_msg_valid = '0;
      @(negedge clk);
      check("wrap_post4",  64'(msg_count_s), 64'h0);
      check("wrap_post32", 64'(msg_count),   64'd16);

      // Async reset while a stalled message sits in the output register.
      tick();
      s_msg_valid = 16'h1000;
      tick();
      s_msg_valid = 16'h1200;
      m_msg_ready = 1'b0;
      #2;
      check("ar_before", 64'(m_msg_valid), 64'h1);
      rst_n = 1'b0;
      #1;
      check("ar_valid_drop", 64'(m_msg_valid), 64'h0);
      check("ar_src_zero",   64'(m_msg_src),   64'h0);
      tick();
      tick();
      m_msg_ready = 1'b1;
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("ar_first_grant", 64'(m_msg_src), 64'h9);
      s_msg_valid = '0;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
